// File: rtl/alu_mux_arbiter.sv
// Four-way arbiter for the shared ALU operand mux: grants one requester for HOLD_CYCLES, then pulses done.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module alu_mux_arbiter #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic [3:0] done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [3:0] done_q, done_d;
    logic [1:0] sel_q, sel_d;
    logic       busy_q, busy_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] win_q, win_d;

    logic [1:0] pick;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        pick = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) begin
                pick = 2'(i);
            end
        end
    end
`else
    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        pick  = 2'd0;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = 4'b0000;
        sel_d   = sel_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        unique case (state_q)
            IDLE: begin
                gnt_d  = 4'b0000;
                busy_d = 1'b0;
                if (req != 4'b0000) begin
                    win_d   = pick;
                    gnt_d   = 4'b0001 << pick;
                    sel_d   = ~pick;
                    busy_d  = 1'b1;
                    cnt_d   = 8'(HOLD_CYCLES - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    gnt_d   = 4'b0000;
                    busy_d  = 1'b0;
                    done_d  = gnt_q;
                    ptr_d   = win_q;
                    state_d = DONE;
                end
            end
            // One idle cycle after done keeps sel stable under any asserted grant.
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            done_q  <= 4'b0000;
            sel_q   <= 2'b11;
            busy_q  <= 1'b0;
            cnt_q   <= 8'd0;
            ptr_q   <= 2'd3;
            win_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign sel  = sel_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_alu_mux_arbiter.sv
// Randomized bench for alu_mux_arbiter against a transaction-level reference model.
// Define ALU_ARB_FIXED_PRIO_EN here too when building the fixed-priority variant.
module tb_alu_mux_arbiter;

    localparam int HOLD = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic [3:0] done;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining grant cycles, pending done cycle, winner and pointer.
    int mHoldLeft = 0;
    bit mDoneNow  = 1'b0;
    int mWinner   = 0;
    int mPtr      = 3;
    int mSel      = 3;

    alu_mux_arbiter #(.HOLD_CYCLES(HOLD)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .gnt  (gnt),
        .sel  (sel),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int chooseWinner(input logic [3:0] r, input int ptr);
`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 4; k++) if (r[k]) return k;
`else
        for (int k = 1; k <= 4; k++) if (r[(ptr + k) % 4]) return (ptr + k) % 4;
`endif
        return -1;
    endfunction

    task automatic modelEdge(input logic [3:0] r, input logic rn);
        if (!rn) begin
            mHoldLeft = 0;
            mDoneNow  = 1'b0;
            mPtr      = 3;
            mSel      = 3;
        end else if (mDoneNow) begin
            mDoneNow = 1'b0;
        end else if (mHoldLeft > 0) begin
            mHoldLeft--;
            if (mHoldLeft == 0) begin
                mDoneNow = 1'b1;
                mPtr     = mWinner;
            end
        end else if (r != 4'b0000) begin
            mWinner   = chooseWinner(r, mPtr);
            mHoldLeft = HOLD;
            mSel      = 3 - mWinner;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic rn);
        logic [3:0] expGnt;
        logic [3:0] expDone;
        @(negedge clk);
        req   = r;
        rst_n = rn;
        @(posedge clk);
        modelEdge(r, rn);
        #1;
        expGnt  = (mHoldLeft > 0) ? 4'(1 << mWinner) : 4'b0000;
        expDone = mDoneNow ? 4'(1 << mWinner) : 4'b0000;
        checkOutput("gnt", 32'(gnt), 32'(expGnt));
        checkOutput("done", 32'(done), 32'(expDone));
        checkOutput("busy", 32'(busy), 32'(mHoldLeft > 0));
        checkOutput("sel", 32'(sel), 32'(mSel));
    endtask

    initial begin
        logic [3:0] reqv;
        // Reset held for two edges with every requester asking.
        applyStimulus(4'b1111, 1'b0);
        applyStimulus(4'b1111, 1'b0);
        checkOutput("rst_gnt_const", 32'(gnt), 32'h0);
        checkOutput("rst_sel_const", 32'(sel), 32'h3);
        applyStimulus(4'b1111, 1'b1);
        checkOutput("first_gnt_const", 32'(gnt), 32'h1);
        checkOutput("first_sel_const", 32'(sel), 32'h3);

        // All requesters held: rotation (or fixed priority) over several rounds.
        for (int i = 0; i < 5 * (HOLD + 2); i++) applyStimulus(4'b1111, 1'b1);

        // Single requester 2, then drop it mid-grant while requester 0 arrives.
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0100, 1'b1);
        checkOutput("single_gnt_const", 32'(gnt), 32'h4);
        checkOutput("single_sel_const", 32'(sel), 32'h1);
        applyStimulus(4'b0001, 1'b1);
        checkOutput("nopreempt_gnt_const", 32'(gnt), 32'h4);
        applyStimulus(4'b0001, 1'b1);
        checkOutput("nopreempt_done_const", 32'(done), 32'h4);
        for (int i = 0; i < 4; i++) applyStimulus(4'b0001, 1'b1);

        // Random traffic: requests persist until their done cycle, occasional resets.
        reqv = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            reqv = reqv | 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            if (mDoneNow) reqv[mWinner] = 1'b0;
            if ($urandom_range(0, 19) == 0) reqv = 4'($urandom_range(0, 15));
            applyStimulus(reqv, ($urandom_range(0, 49) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
